// File: rtl/tick_ctrl_pkg.sv
// rtl/tick_ctrl_pkg.sv - shared types and constants for the tick controller
package tick_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } tick_state_t;

    localparam int DEFAULT_TAP_C = 25;

endpackage

// File: rtl/tap_edge_detect.sv
// rtl/tap_edge_detect.sv - rising-edge detector on one selectable tap of the divider bus
// Ports: divided_clocks (divider bus), sel (tap in use), reload/reload_tap (tap is
// switching this edge; resample the new tap), rise (combinational edge strobe).
module tap_edge_detect (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] divided_clocks,
    input  logic [4:0]  sel,
    input  logic        reload,
    input  logic [4:0]  reload_tap,
    output logic        rise
);

    logic prev_bit;

    // On a tap switch, history is taken from the new tap so its current
    // level is not mistaken for a fresh edge on the following cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_bit <= 1'b0;
        end else if (reload) begin
            prev_bit <= divided_clocks[reload_tap];
        end else begin
            prev_bit <= divided_clocks[sel];
        end
    end

    assign rise = divided_clocks[sel] & ~prev_bit;

endmodule

// File: rtl/tick_controller.sv
// rtl/tick_controller.sv - run/step/idle gating of divider-tap edges into single-cycle ticks
// Ports: divided_clocks/tap_sel/tap_load pick the tap, run/step drive the FSM,
// tick/tick_count report issued ticks, active_tap/tap_pending/state are status.
module tick_controller
    import tick_ctrl_pkg::*;
#(
    parameter int DEFAULT_TAP = DEFAULT_TAP_C,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      divided_clocks,
    input  logic [4:0]       tap_sel,
    input  logic             tap_load,
    input  logic             run,
    input  logic             step,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
    output logic [4:0]       active_tap,
    output logic             tap_pending,
    output logic [1:0]       state
);

    tick_state_t state_r, state_d;
    logic [4:0]  pending_tap;
    logic [4:0]  tap_d, pending_tap_d;
    logic        tap_pending_d;
    logic        reload;
    logic        rise;
    logic        tick_d;
    logic        go_idle;

    tap_edge_detect u_edge (
        .clock          (clock),
        .reset          (reset),
        .divided_clocks (divided_clocks),
        .sel            (active_tap),
        .reload         (reload),
        .reload_tap     (tap_d),
        .rise           (rise)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_d;
        end
    end

    always_comb begin
        state_d = state_r;
        case (state_r)
            IDLE: begin
                if (run) begin
                    state_d = RUN;
                end else if (step) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (!run) begin
                    state_d = IDLE;
                end
            end
            STEP: begin
                // run takes over without an extra tick; otherwise one edge ends the step
                if (run) begin
                    state_d = RUN;
                end else if (rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gating uses the registered state, so the edge that ends a step or
    // coincides with run dropping still produces its tick.
    assign tick_d  = (state_r == RUN || state_r == STEP) && rise;
    assign go_idle = (state_r != IDLE) && (state_d == IDLE);

    // Tap changes while ticking wait for an edge so the outgoing tap's tick
    // completes first; leaving for IDLE flushes any waiting change at once.
    always_comb begin
        tap_d         = active_tap;
        pending_tap_d = pending_tap;
        tap_pending_d = tap_pending;
        reload        = 1'b0;
        if (state_r == IDLE) begin
            if (tap_load) begin
                tap_d  = tap_sel;
                reload = 1'b1;
            end
        end else if (go_idle) begin
            if (tap_load) begin
                tap_d         = tap_sel;
                reload        = 1'b1;
                tap_pending_d = 1'b0;
            end else if (tap_pending) begin
                tap_d         = pending_tap;
                reload        = 1'b1;
                tap_pending_d = 1'b0;
            end
        end else begin
            if (tap_pending && rise) begin
                tap_d         = pending_tap;
                reload        = 1'b1;
                tap_pending_d = 1'b0;
            end
            if (tap_load) begin
                pending_tap_d = tap_sel;
                tap_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick        <= 1'b0;
            tick_count  <= '0;
            active_tap  <= 5'(DEFAULT_TAP);
            pending_tap <= 5'd0;
            tap_pending <= 1'b0;
        end else begin
            tick        <= tick_d;
            active_tap  <= tap_d;
            pending_tap <= pending_tap_d;
            tap_pending <= tap_pending_d;
            if (tick_d) begin
                tick_count <= tick_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_tick_controller.sv
// tb/tb_tick_controller.sv - scoreboard bench for tick_controller against a behavioural model
module tb_tick_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] divided_clocks = 32'd0;
    logic [4:0]  tap_sel = 5'd0;
    logic        tap_load = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        tick;
    logic [15:0] tick_count;
    logic [4:0]  active_tap;
    logic        tap_pending;
    logic [1:0]  state;

    tick_controller #(.DEFAULT_TAP(25), .CNT_W(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .divided_clocks (divided_clocks),
        .tap_sel        (tap_sel),
        .tap_load       (tap_load),
        .run            (run),
        .step           (step),
        .tick           (tick),
        .tick_count     (tick_count),
        .active_tap     (active_tap),
        .tap_pending    (tap_pending),
        .state          (state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) divided_clocks <= divided_clocks + 32'd1;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;
    exp_t exp_q[$];

    // model: 0 idle, 1 run, 2 step
    int m_mode = 0;
    int m_tap = 25;
    int m_pend = 0;
    int m_ptap = 0;
    int m_count = 0;

    // tap k is high for the second half of every 2^(k+1)-count window
    function automatic bit rise_at(input logic [31:0] v, input int k);
        longint period;
        period = longint'(1) << (k + 1);
        return (longint'(v) % period) == (longint'(1) << k);
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clock) begin
        int nxt;
        bit r;
        bit go_idle;
        exp_t e;
        if (reset) begin
            m_mode  = 0;
            m_tap   = 25;
            m_pend  = 0;
            m_ptap  = 0;
            m_count = 0;
            exp_q.delete();
        end else begin
            check("state", longint'(state), m_mode);
            check("active_tap", longint'(active_tap), m_tap);
            check("tap_pending", longint'(tap_pending), m_pend);
            check("tick_count", longint'(tick_count), m_count % 65536);
            r = rise_at(divided_clocks, m_tap);
            nxt = m_mode;
            case (m_mode)
                0: if (run) nxt = 1; else if (step) nxt = 2;
                1: if (!run) nxt = 0;
                default: if (run) nxt = 1; else if (r) nxt = 0;
            endcase
            if (m_mode != 0 && r) begin
                m_count++;
                e.cyc = cyc + 1;
                e.cnt = m_count % 65536;
                exp_q.push_back(e);
            end
            go_idle = (m_mode != 0) && (nxt == 0);
            if (m_mode == 0) begin
                if (tap_load) m_tap = int'(tap_sel);
            end else if (go_idle) begin
                if (tap_load) begin
                    m_tap = int'(tap_sel);
                    m_pend = 0;
                end else if (m_pend != 0) begin
                    m_tap = m_ptap;
                    m_pend = 0;
                end
            end else begin
                if (m_pend != 0 && r) begin
                    m_tap = m_ptap;
                    m_pend = 0;
                end
                if (tap_load) begin
                    m_ptap = int'(tap_sel);
                    m_pend = 1;
                end
            end
            m_mode = nxt;
        end
    end

    always @(posedge clock) begin
        exp_t e;
        #2;
        if (!reset) begin
            if (tick) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_tick: got tick=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("tick_cycle", cyc, e.cyc);
                    check("tick_cnt", longint'(tick_count), e.cnt);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                check("tick_seen", longint'(tick), 1);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic load_tap(input int t);
        tap_sel  = 5'(t);
        tap_load = 1'b1;
        cycles(1);
        tap_load = 1'b0;
    endtask

    initial begin
        int base;
        int want;
        int r;
        reset = 1'b1;
        cycles(20);
        check("rst_tick", longint'(tick), 0);
        check("rst_count", longint'(tick_count), 0);
        check("rst_tap", longint'(active_tap), 25);
        check("rst_state", longint'(state), 0);
        check("rst_pending", longint'(tap_pending), 0);
        reset = 1'b0;
        cycles(3);

        load_tap(0);
        cycles(2);
        check("tap0_loaded", longint'(active_tap), 0);
        run = 1'b1;
        for (int i = 0; i < 60 && tick_count < 16'd10; i++) cycles(1);
        check("ten_ticks", longint'(tick_count), 10);
        run = 1'b0;
        cycles(4);

        load_tap(1);
        cycles(2);
        base = m_count;
        step = 1'b1;
        cycles(1);
        step = 1'b0;
        cycles(6);
        check("step1_count", longint'(tick_count), base + 1);
        check("step1_idle", longint'(state), 0);
        step = 1'b1;
        cycles(1);
        step = 1'b0;
        cycles(6);
        check("step2_count", longint'(tick_count), base + 2);

        load_tap(0);
        run = 1'b1;
        cycles(7);
        load_tap(2);
        check("pend_set", longint'(tap_pending), 1);
        cycles(40);
        check("tap2_active", longint'(active_tap), 2);
        run = 1'b0;
        cycles(10);

        run  = 1'b1;
        step = 1'b1;
        cycles(1);
        step = 1'b0;
        check("run_prio", longint'(state), 1);
        for (int i = 0; i < 20 && !rise_at(divided_clocks, 2); i++) cycles(1);
        want = m_count + 1;
        run = 1'b0;
        cycles(20);
        check("drop_run_count", longint'(tick_count), want);

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) run = ~run;
            step     = (r >= 3 && r < 8);
            tap_load = (r >= 8 && r < 13);
            tap_sel  = 5'($urandom_range(0, 4));
            cycles(1);
        end
        step     = 1'b0;
        tap_load = 1'b0;
        run      = 1'b0;
        cycles(40);

        load_tap(3);
        run = 1'b1;
        cycles(20);
        load_tap(0);
        check("pend_before_rst", longint'(tap_pending), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_tick", longint'(tick), 0);
        check("mid_rst_count", longint'(tick_count), 0);
        check("mid_rst_tap", longint'(active_tap), 25);
        check("mid_rst_pending", longint'(tap_pending), 0);
        check("mid_rst_state", longint'(state), 0);
        run = 1'b0;
        cycles(3);
        reset = 1'b0;
        cycles(5);
        check("post_rst_count", longint'(tick_count), 0);
        check("post_rst_tap", longint'(active_tap), 25);

        cycles(5);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
